// File: rtl/hilo_divider_if.sv
// ============================================================================
// hilo_divider_if : EX-stage request/result bundle for the HI/LO divider
// Revision        : 1.0
// ============================================================================
`default_nettype none

interface hilo_divider_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              signed_div;
    logic              annul;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              stall_req;
    logic              done;
    logic [DATA_W-1:0] result_hi;
    logic [DATA_W-1:0] result_lo;

    modport master (
        output start, signed_div, annul, op_a, op_b,
        input  stall_req, done, result_hi, result_lo
    );

    modport slave (
        input  start, signed_div, annul, op_a, op_b,
        output stall_req, done, result_hi, result_lo
    );
endinterface

`default_nettype wire

// File: rtl/hilo_divider.sv
// ============================================================================
// hilo_divider : multi-cycle radix-2 restoring DIV/DIVU, quotient->LO, rem->HI
// Optional     : DIV_EARLY_OUT_EN skips iteration when |op_a| < |op_b|
// Revision     : 1.0
// ============================================================================
`default_nettype none

module hilo_divider #(
    parameter int DATA_W = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    hilo_divider_if.slave    bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ZERO   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem, r_quo, r_divisor, r_opa;
    logic [DATA_W-1:0] r_hi, r_lo;
    logic              r_sdiv, r_sa, r_sb, r_done;

    logic              w_accept, w_b_zero, w_short;
    logic [DATA_W-1:0] w_abs_a, w_abs_b;
    logic [DATA_W:0]   w_shift;
    logic              w_ge;
    logic [DATA_W-1:0] w_sub, w_rem_nx, w_quo_nx;
    logic              w_neg_q, w_neg_r;

    assign w_accept = bus.start & ~bus.annul;
    assign w_b_zero = (bus.op_b == '0);
    assign w_abs_a  = (bus.signed_div & bus.op_a[DATA_W-1]) ? -bus.op_a : bus.op_a;
    assign w_abs_b  = (bus.signed_div & bus.op_b[DATA_W-1]) ? -bus.op_b : bus.op_b;

`ifdef DIV_EARLY_OUT_EN
    logic r_early;
    assign w_short = w_b_zero | (w_abs_a < w_abs_b);
`else
    assign w_short = w_b_zero;
`endif

    // Partial remainder is always below the divisor, so the shifted value
    // fits DATA_W+1 bits and a successful subtract fits back in DATA_W.
    assign w_shift  = {r_rem, r_quo[DATA_W-1]};
    assign w_ge     = (w_shift >= {1'b0, r_divisor});
    assign w_sub    = w_shift[DATA_W-1:0] - r_divisor;
    assign w_rem_nx = w_ge ? w_sub : w_shift[DATA_W-1:0];
    assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};
    assign w_neg_q  = r_sdiv & (r_sa ^ r_sb);
    assign w_neg_r  = r_sdiv & r_sa;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = w_short ? S_ZERO : S_DIV;
            S_ZERO:   w_next = S_FINISH;
            S_DIV:    if (r_cnt == C_LAST) w_next = S_FINISH;
            S_FINISH: if (!bus.start) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (bus.annul) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_opa     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_sdiv    <= 1'b0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_done    <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            r_early   <= 1'b0;
`endif
        end else if (bus.annul) begin
            r_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_sdiv    <= bus.signed_div;
                    r_sa      <= bus.op_a[DATA_W-1];
                    r_sb      <= bus.op_b[DATA_W-1];
                    r_opa     <= bus.op_a;
                    r_divisor <= w_abs_b;
                    r_quo     <= w_abs_a;
                    r_rem     <= '0;
                    r_cnt     <= '0;
`ifdef DIV_EARLY_OUT_EN
                    r_early   <= ~w_b_zero;
`endif
                end
                S_ZERO: begin
                    r_done <= 1'b1;
                    r_hi   <= r_opa;
`ifdef DIV_EARLY_OUT_EN
                    r_lo   <= r_early ? '0 : '1;
`else
                    r_lo   <= '1;
`endif
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_done <= 1'b1;
                        r_lo   <= w_neg_q ? -w_quo_nx : w_quo_nx;
                        r_hi   <= w_neg_r ? -w_rem_nx : w_rem_nx;
                    end
                end
                S_FINISH: if (!bus.start) r_done <= 1'b0;
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign bus.stall_req = ((r_state == S_IDLE) & w_accept) |
                           (r_state == S_DIV) | (r_state == S_ZERO);
    assign bus.done      = r_done;
    assign bus.result_hi = r_hi;
    assign bus.result_lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_divider.sv
// ============================================================================
// tb_hilo_divider : directed + scoreboard bench for hilo_divider
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_hilo_divider;
    localparam int DATA_W = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int C_SHORT_LAT = 2;
`else
    localparam int C_SHORT_LAT = DATA_W + 1;
`endif

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];
    logic [31:0] last_lo, last_hi;

    hilo_divider_if #(.DATA_W(DATA_W)) bus ();

    hilo_divider #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sd, input logic [31:0] elo, input logic [31:0] ehi,
                          input int elat);
        exp_t e;
        int   n;
        logic stall_ok;
        e.lo = elo; e.hi = ehi; e.lat = elat;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.op_a = a; bus.op_b = b; bus.signed_div = sd; bus.start = 1'b1;
        #1;
        check({tag, "_stall_idle"}, 64'(bus.stall_req), 64'd1);
        n = 0;
        stall_ok = 1'b1;
        while (!bus.done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) begin
                bus.op_a = $urandom; bus.op_b = $urandom; bus.signed_div = ~sd;
            end
            if (!bus.done && !bus.stall_req) stall_ok = 1'b0;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 64'(n), 64'(e.lat));
        check({tag, "_lo"}, 64'(bus.result_lo), 64'(e.lo));
        check({tag, "_hi"}, 64'(bus.result_hi), 64'(e.hi));
        check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
        check({tag, "_stall_finish"}, 64'(bus.stall_req), 64'd0);
        @(posedge clk); #1;
        check({tag, "_finish_hold"}, 64'(bus.done), 64'd1);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_done_clear"}, 64'(bus.done), 64'd0);
        check({tag, "_lo_persist"}, 64'(bus.result_lo), 64'(e.lo));
        last_lo = e.lo;
        last_hi = e.hi;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        seen_done;
        total = 0;
        bad   = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
        bus.op_a = '0; bus.op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_lo", 64'(bus.result_lo), 64'd0);
        check("reset_hi", 64'(bus.result_hi), 64'd0);
        check("reset_stall", 64'(bus.stall_req), 64'd0);
        rst = 1'b1;

        run_op("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,        33);
        run_op("s-7_2",    32'hFFFF_FFF9,  32'h0000_0002,  1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF, 33);
        run_op("uF9_2",    32'hFFFF_FFF9,  32'h0000_0002,  1'b0, 32'h7FFF_FFFC,  32'd1,        33);
        run_op("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,        33);
        run_op("s5_0",     32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,        2);
        run_op("u5_0",     32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,        2);
        run_op("u3_10",    32'd3,          32'd10,         1'b0, 32'd0,          32'd3,        C_SHORT_LAT);
        run_op("s-3_10",   32'hFFFF_FFFD,  32'd10,         1'b1, 32'd0,          32'hFFFF_FFFD, C_SHORT_LAT);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 100000);
            run_op("urand_big", ra, rb, 1'b0, ra / rb, ra % rb, 33);
        end
        ra = $urandom_range(0, 50);
        rb = $urandom_range(51, 5000);
        run_op("urand_small", ra, rb, 1'b0, 32'd0, ra, C_SHORT_LAT);

        // annul at iteration 10 of 100/7
        @(posedge clk); #1;
        bus.op_a = 32'd100; bus.op_b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("annul_pre_stall", 64'(bus.stall_req), 64'd1);
        bus.annul = 1'b1;
        @(posedge clk); #1;
        check("annul_stall", 64'(bus.stall_req), 64'd0);
        check("annul_done", 64'(bus.done), 64'd0);
        check("annul_lo_kept", 64'(bus.result_lo), 64'(last_lo));
        check("annul_hi_kept", 64'(bus.result_hi), 64'(last_hi));
        bus.annul = 1'b0;
        bus.start = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1'b1;
        end
        check("annul_no_done", 64'(seen_done), 64'd0);

        // async reset pulse mid-DIV
        @(posedge clk); #1;
        bus.op_a = 32'd100; bus.op_b = 32'd7; bus.start = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        bus.start = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_lo", 64'(bus.result_lo), 64'd0);
        check("rst_hi", 64'(bus.result_hi), 64'd0);
        check("rst_stall", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
